sq_datamover_cmd_issuer: RTL
============================

Name: sq_datamover_cmd_issuer

Overview:
- Consumes decoded RDMA SQ entries (id, opcode, flags, keys, btt, entry-valid pulse) from the SQ AXIS receiver stage.
- Turns each valid WRITE entry into one Xilinx AXI DataMover MM2S command on an AXIS master.
- Waits for the matching DataMover status, then emits one completion record per entry.
- Sits between the SQ entry decoder and the DataMover IP. It is the command/status half of the data mover controller.

Parameters:
- C_ADDR_WIDTH, 64: DataMover source address width; taken from rdma_local_key.
- C_BTT_WIDTH, 23: DataMover BTT field width; taken from rdma_btt.
- C_STS_TIMEOUT, 65535: cycles to wait in WAIT_STS before declaring a timeout; must be ≥ 1.

Ports:
- S_AXIS_ACLK in 1: clock.
- S_AXIS_ARESETN in 1: asynchronous active-low reset.
- rdma_id in 32: entry identifier.
- rdma_opcode in 16: operation code.
- rdma_flags in 16: flags; bit0 = EOF request.
- rdma_local_key in 64: source address.
- rdma_remote_key in 64: unused here; latched and echoed on cpl_remote_key.
- rdma_btt in 128: bytes to transfer.
- rdma_entry_valid in 1: single-cycle entry strobe. There is no backpressure.
- M_AXIS_CMD_TDATA out 104: DataMover command.
- M_AXIS_CMD_TVALID out 1: command valid.
- M_AXIS_CMD_TREADY in 1: command ready.
- S_AXIS_STS_TDATA in 8: DataMover status {OKAY, SLVERR, DECERR, INTERR, TAG[3:0]}.
- S_AXIS_STS_TVALID in 1: status valid.
- S_AXIS_STS_TREADY out 1: status ready.
- cpl_valid out 1: single-cycle completion pulse.
- cpl_id out 32: id of the completed entry.
- cpl_remote_key out 64: remote_key of the completed entry.
- cpl_status out 3: completion status code (see Behaviour).
- busy out 1: high while the FSM is not in IDLE or the pending slot is full.
- drop_count out 16: saturating count of entries dropped on overflow.

Behaviour:
- Reset: all outputs are 0; FSM goes to IDLE; pending slot empty; tag counter 0. Reset may assert at any time, including mid-WAIT_STS. It clears everything immediately and no completion is emitted for the in-flight entry.
- Pending slot (1 deep):
  - rdma_entry_valid with slot empty, or with slot being consumed this cycle: capture all fields into the slot.
  - rdma_entry_valid with slot full and not being consumed: drop the entry; drop_count increments, saturating at 0xFFFF.
- FSM states: IDLE, SEND_CMD, WAIT_STS, REPORT.
- IDLE, slot full: move the slot into the active registers, clear the slot, then validate:
  - opcode != 0x0001 → status 4 (BAD_OPCODE).
  - btt[127:C_BTT_WIDTH] != 0 or btt[C_BTT_WIDTH-1:0] == 0 → status 5 (BAD_LEN).
  - Any failure → go to REPORT and issue no command. Otherwise go to SEND_CMD.
- SEND_CMD:
  - M_AXIS_CMD_TVALID = 1.
  - TDATA = {4'b0, tag[3:0], saddr[63:0], DRR=0, EOF=flags[0], DSA=6'b0, TYPE=1, BTT[22:0]}, MSB to LSB.
  - TDATA is held stable until TREADY. On TVALID && TREADY go to WAIT_STS.
- WAIT_STS:
  - S_AXIS_STS_TREADY = 1; timeout counter runs.
  - On a status handshake, the status code is chosen in this priority order:
    - TAG != active tag → 7 (TAG_MISMATCH).
    - INTERR → 3.
    - DECERR → 2.
    - SLVERR → 1.
    - OKAY → 0.
    - OKAY clear with no error bit set → 3.
  - Counter reaching C_STS_TIMEOUT with no status → 6 (TIMEOUT).
  - In all cases go to REPORT. The tag counter increments (mod 16) on leaving WAIT_STS.
- REPORT: cpl_valid = 1 for exactly one cycle with cpl_id, cpl_remote_key and cpl_status; then go to IDLE.
- Latency and throughput:
  - Minimum entry-strobe to TVALID is 2 cycles (capture, then IDLE→SEND_CMD).
  - Status handshake to cpl_valid is 1 cycle.
  - An entry rejected on validation reaches cpl_valid 2 cycles after its strobe.
  - Completions are in order; at most one command is outstanding.
- Status beats arriving outside WAIT_STS are not accepted (TREADY = 0).

Decomposition:
- Shared package sq_dm_pkg:
  - Opcode constant OP_WRITE = 16'h0001.
  - Completion status codes 0–7.
  - Command field offsets and the 104-bit command width.
  - Status bit positions.
- Sub-module sq_entry_slot: the 1-deep capture register with drop counter. The FSM and command/status logic stay in the top.

Test Plan:
- Write, happy path: strobe id=0x11, opcode=1, local_key=0x0000_0001_0000_1000, btt=256, flags=1 → command BTT=256, TYPE=1, EOF=1, SADDR=0x1_0000_1000, tag=0; status 0x80 → cpl_valid with id 0x11, status 0.
- Bad requests: opcode=0x0002 → no TVALID, cpl status 4 two cycles after the strobe. btt=0 → status 5. btt=1<<23 → status 5.
- Status errors: status 0x40 (SLVERR) → status 1. Status with tag 3 while active tag is 0 → status 7; the tag counter advances to 1.
- Overflow: three strobes 1 cycle apart while TREADY is held low → first entry active, second in the slot, third dropped. drop_count=1; completions for the first two only, in order.
- Timeout: C_STS_TIMEOUT=16, no status → cpl status 6 after 16 cycles in WAIT_STS. A subsequent entry proceeds normally.
- Reset mid-operation: assert S_AXIS_ARESETN=0 in WAIT_STS → all outputs 0 immediately and no cpl_valid. After release, a fresh entry issues with tag 0.

Source files
------------

// File: rtl/sq_dm_pkg.sv
// Shared definitions for the SQ DataMover command issuer: opcodes, completion
// codes, MM2S command layout and status bit positions.
package sq_dm_pkg;

  localparam logic [15:0] OP_WRITE = 16'h0001;

  typedef enum logic [2:0] {
    CPL_OKAY         = 3'd0,
    CPL_SLVERR       = 3'd1,
    CPL_DECERR       = 3'd2,
    CPL_INTERR       = 3'd3,
    CPL_BAD_OPCODE   = 3'd4,
    CPL_BAD_LEN      = 3'd5,
    CPL_TIMEOUT      = 3'd6,
    CPL_TAG_MISMATCH = 3'd7
  } cpl_status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_STS,
    ST_REPORT
  } fsm_state_e;

  // MM2S command layout, LSB first.
  localparam int CMD_W         = 104;
  localparam int CMD_BTT_LSB   = 0;
  localparam int CMD_TYPE_BIT  = 23;
  localparam int CMD_DSA_LSB   = 24;
  localparam int CMD_EOF_BIT   = 30;
  localparam int CMD_DRR_BIT   = 31;
  localparam int CMD_SADDR_LSB = 32;
  localparam int CMD_TAG_LSB   = 96;
  localparam int CMD_RSVD_LSB  = 100;

  localparam int STS_TAG_LSB    = 0;
  localparam int STS_INTERR_BIT = 4;
  localparam int STS_DECERR_BIT = 5;
  localparam int STS_SLVERR_BIT = 6;
  localparam int STS_OKAY_BIT   = 7;

  typedef struct packed {
    logic [31:0]  id;
    logic [15:0]  opcode;
    logic [15:0]  flags;
    logic [63:0]  local_key;
    logic [63:0]  remote_key;
    logic [127:0] btt;
  } sq_entry_t;

  function automatic logic [CMD_W-1:0] build_cmd(input logic [3:0]  tag,
                                                 input logic [63:0] saddr,
                                                 input logic        eof,
                                                 input logic [22:0] btt);
    return {4'b0, tag, saddr, 1'b0, eof, 6'b0, 1'b1, btt};
  endfunction

endpackage

// File: rtl/sq_entry_slot.sv
// One-deep capture register for decoded SQ entries; entries arriving while the
// slot is occupied and not being drained are dropped and counted.
module sq_entry_slot
  import sq_dm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        entry_valid_i,
  input  sq_entry_t   entry_i,
  input  logic        consume_i,
  output logic        full_o,
  output sq_entry_t   entry_o,
  output logic [15:0] drop_count_o
);

  logic        full_q;
  sq_entry_t   entry_q;
  logic [15:0] drop_q;
  logic        capture;
  logic        drop;

  // A slot being drained this cycle can take the new entry at the same edge.
  assign capture = entry_valid_i && (!full_q || consume_i);
  assign drop    = entry_valid_i && full_q && !consume_i;

  // NOTE: state registers use non-blocking assignments and reset asynchronously;
  // the entry payload is reset as well so nothing stale is visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
      drop_q  <= '0;
    end else begin
      full_q <= capture || (full_q && !consume_i);
      if (capture) entry_q <= entry_i;
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign full_o       = full_q;
  assign entry_o      = entry_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/sq_datamover_cmd_issuer.sv
// Turns valid SQ WRITE entries into AXI DataMover MM2S commands, waits for the
// matching status and emits one in-order completion per entry.
module sq_datamover_cmd_issuer
  import sq_dm_pkg::*;
#(
  parameter int C_ADDR_WIDTH  = 64,
  parameter int C_BTT_WIDTH   = 23,
  parameter int C_STS_TIMEOUT = 65535
) (
  input  logic               S_AXIS_ACLK,
  input  logic               S_AXIS_ARESETN,
  input  logic [31:0]        rdma_id,
  input  logic [15:0]        rdma_opcode,
  input  logic [15:0]        rdma_flags,
  input  logic [63:0]        rdma_local_key,
  input  logic [63:0]        rdma_remote_key,
  input  logic [127:0]       rdma_btt,
  input  logic               rdma_entry_valid,
  output logic [CMD_W-1:0]   M_AXIS_CMD_TDATA,
  output logic               M_AXIS_CMD_TVALID,
  input  logic               M_AXIS_CMD_TREADY,
  input  logic [7:0]         S_AXIS_STS_TDATA,
  input  logic               S_AXIS_STS_TVALID,
  output logic               S_AXIS_STS_TREADY,
  output logic               cpl_valid,
  output logic [31:0]        cpl_id,
  output logic [63:0]        cpl_remote_key,
  output logic [2:0]         cpl_status,
  output logic               busy,
  output logic [15:0]        drop_count
);

  localparam int TMO_W = $clog2(C_STS_TIMEOUT + 1);

  fsm_state_e              state_q, state_d;
  logic [3:0]              tag_q, tag_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [31:0]             id_q, id_d;
  logic [63:0]             rkey_q, rkey_d;
  logic [C_ADDR_WIDTH-1:0] saddr_q, saddr_d;
  logic                    eof_q, eof_d;
  logic [C_BTT_WIDTH-1:0]  btt_q, btt_d;
  cpl_status_e             status_q, status_d;

  sq_entry_t  slot_entry;
  sq_entry_t  in_entry;
  logic       slot_full;
  logic       consume;
  logic       op_ok;
  logic       len_ok;
  logic       sts_hs;
  cpl_status_e sts_code;

  assign in_entry = '{id:         rdma_id,
                      opcode:     rdma_opcode,
                      flags:      rdma_flags,
                      local_key:  rdma_local_key,
                      remote_key: rdma_remote_key,
                      btt:        rdma_btt};

  sq_entry_slot u_slot (
    .clk           (S_AXIS_ACLK),
    .rst_n         (S_AXIS_ARESETN),
    .entry_valid_i (rdma_entry_valid),
    .entry_i       (in_entry),
    .consume_i     (consume),
    .full_o        (slot_full),
    .entry_o       (slot_entry),
    .drop_count_o  (drop_count)
  );

  assign op_ok  = (slot_entry.opcode == OP_WRITE);
  assign len_ok = ((slot_entry.btt >> C_BTT_WIDTH) == 128'd0) &&
                  (slot_entry.btt[C_BTT_WIDTH-1:0] != '0);

  assign sts_hs = (state_q == ST_WAIT_STS) && S_AXIS_STS_TVALID;

  // A wrong tag outranks any error bits; OKAY with no error bit is still treated as internal error.
  always_comb begin
    sts_code = CPL_INTERR;
    if (S_AXIS_STS_TDATA[STS_TAG_LSB +: 4] != tag_q) sts_code = CPL_TAG_MISMATCH;
    else if (S_AXIS_STS_TDATA[STS_INTERR_BIT])        sts_code = CPL_INTERR;
    else if (S_AXIS_STS_TDATA[STS_DECERR_BIT])        sts_code = CPL_DECERR;
    else if (S_AXIS_STS_TDATA[STS_SLVERR_BIT])        sts_code = CPL_SLVERR;
    else if (S_AXIS_STS_TDATA[STS_OKAY_BIT])          sts_code = CPL_OKAY;
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    tmo_d    = tmo_q;
    id_d     = id_q;
    rkey_d   = rkey_q;
    saddr_d  = saddr_q;
    eof_d    = eof_q;
    btt_d    = btt_q;
    status_d = status_q;
    consume  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (slot_full) begin
          consume  = 1'b1;
          id_d     = slot_entry.id;
          rkey_d   = slot_entry.remote_key;
          saddr_d  = slot_entry.local_key[C_ADDR_WIDTH-1:0];
          eof_d    = slot_entry.flags[0];
          btt_d    = slot_entry.btt[C_BTT_WIDTH-1:0];
          status_d = CPL_OKAY;
          if (!op_ok) begin
            status_d = CPL_BAD_OPCODE;
            state_d  = ST_REPORT;
          end else if (!len_ok) begin
            status_d = CPL_BAD_LEN;
            state_d  = ST_REPORT;
          end else begin
            state_d  = ST_SEND_CMD;
          end
        end
      end
      ST_SEND_CMD: begin
        if (M_AXIS_CMD_TREADY) begin
          tmo_d   = '0;
          state_d = ST_WAIT_STS;
        end
      end
      ST_WAIT_STS: begin
        if (sts_hs) begin
          status_d = sts_code;
          tag_d    = tag_q + 4'd1;
          state_d  = ST_REPORT;
        end else if (tmo_q == TMO_W'(C_STS_TIMEOUT - 1)) begin
          status_d = CPL_TIMEOUT;
          tag_d    = tag_q + 4'd1;
          state_d  = ST_REPORT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q  <= ST_IDLE;
      tag_q    <= '0;
      tmo_q    <= '0;
      id_q     <= '0;
      rkey_q   <= '0;
      saddr_q  <= '0;
      eof_q    <= 1'b0;
      btt_q    <= '0;
      status_q <= CPL_OKAY;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      tmo_q    <= tmo_d;
      id_q     <= id_d;
      rkey_q   <= rkey_d;
      saddr_q  <= saddr_d;
      eof_q    <= eof_d;
      btt_q    <= btt_d;
      status_q <= status_d;
    end
  end

  // Command and completion buses read zero outside their valid windows.
  assign M_AXIS_CMD_TVALID = (state_q == ST_SEND_CMD);
  assign M_AXIS_CMD_TDATA  = M_AXIS_CMD_TVALID ?
                             build_cmd(tag_q, 64'(saddr_q), eof_q, 23'(btt_q)) : '0;
  assign S_AXIS_STS_TREADY = (state_q == ST_WAIT_STS);

  assign cpl_valid      = (state_q == ST_REPORT);
  assign cpl_id         = cpl_valid ? id_q : '0;
  assign cpl_remote_key = cpl_valid ? rkey_q : '0;
  assign cpl_status     = cpl_valid ? status_q : CPL_OKAY;

  assign busy = (state_q != ST_IDLE) || slot_full;

endmodule
